// File: rtl/redmule_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_pkg
//  Description : Shared memory-word parameters and byte-enable merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package redmule_pkg;

  localparam int unsigned MemDw    = 32;
  localparam int unsigned MemBytes = MemDw / 8;

  function automatic logic [MemDw-1:0] be_merge(
    input logic [MemDw-1:0]    old_word,
    input logic [MemDw-1:0]    new_word,
    input logic [MemBytes-1:0] be
  );
    logic [MemDw-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MemBytes; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/redmule_tcdm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_tcdm_bank
//  Description : One TCDM bank: round-robin arbiter, word storage and the
//                registered response (valid, winning port, data).
//  Revision    : 1.0 - initial release
// ============================================================================
module redmule_tcdm_bank
  import redmule_pkg::*;
#(
  parameter  int unsigned MP    = 4,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1,
  localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic [MP-1:0]                req_i,
  input  logic [MP-1:0][ROW_W-1:0]     row_i,
  input  logic [MP-1:0]                wen_i,
  input  logic [MP-1:0][MemBytes-1:0]  be_i,
  input  logic [MP-1:0][MemDw-1:0]     wdata_i,
  output logic [MP-1:0]                gnt_o,
  output logic                         rvalid_o,
  output logic [PTR_W-1:0]             rport_o,
  output logic [MemDw-1:0]             rdata_o
);

  logic [MemDw-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    ptr_q;
  logic                rvalid_q;
  logic [PTR_W-1:0]    rport_q;
  logic [MemDw-1:0]    rdata_q;

  logic                w_win_valid;
  logic [PTR_W-1:0]    w_win_idx;
  logic [PTR_W-1:0]    w_cand;
  logic [31:0]         w_sum;
  logic                w_fire;
  logic [PTR_W-1:0]    w_next_ptr;
  logic [ROW_W-1:0]    w_row;
  logic                w_wen;
  logic [MemBytes-1:0] w_be;
  logic [MemDw-1:0]    w_wdata;

  // Scan ports starting at the pointer, wrapping; first requester wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    w_sum       = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      w_sum = 32'(ptr_q) + i;
      if (w_sum >= MP) w_sum = w_sum - MP;
      w_cand = PTR_W'(w_sum);
      if (!w_win_valid && req_i[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_fire     = w_win_valid & ~stall_i & ~rst_i;
  assign w_next_ptr = (w_win_idx == PTR_W'(MP - 1)) ? '0 : w_win_idx + PTR_W'(1);
  assign w_row      = row_i[w_win_idx];
  assign w_wen      = wen_i[w_win_idx];
  assign w_be       = be_i[w_win_idx];
  assign w_wdata    = wdata_i[w_win_idx];

  always_comb begin
    gnt_o = '0;
    if (w_fire) gnt_o[w_win_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      rport_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= w_fire;
      if (w_fire) begin
        ptr_q   <= w_next_ptr;
        rport_q <= w_win_idx;
        rdata_q <= w_wen ? mem_q[w_row] : '0;
      end
    end
  end

  // Storage carries no reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (w_fire && !w_wen) begin
      mem_q[w_row] <= be_merge(mem_q[w_row], w_wdata, w_be);
    end
  end

  assign rvalid_o = rvalid_q;
  assign rport_o  = rport_q;
  assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: rtl/redmule_tcdm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_tcdm_responder
//  Description : Multi-port word-interleaved TCDM model with per-bank
//                round-robin arbitration and single-cycle responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module redmule_tcdm_responder
  import redmule_pkg::*;
#(
  parameter int unsigned MP    = 4,
  parameter int unsigned NB    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic [MP-1:0]                tcdm_req_i,
  output logic [MP-1:0]                tcdm_gnt_o,
  input  logic [MP-1:0][31:0]          tcdm_add_i,
  input  logic [MP-1:0]                tcdm_wen_i,
  input  logic [MP-1:0][MemBytes-1:0]  tcdm_be_i,
  input  logic [MP-1:0][MemDw-1:0]     tcdm_data_i,
  output logic [MP-1:0][MemDw-1:0]     tcdm_r_data_o,
  output logic [MP-1:0]                tcdm_r_valid_o,
  output logic                         tcdm_r_opc_o,
  output logic                         tcdm_r_user_o
);

  localparam int unsigned NB_LOG2 = $clog2(NB);
  localparam int unsigned BANK_W  = (NB > 1) ? NB_LOG2 : 1;
  localparam int unsigned ROW_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W   = (MP > 1) ? $clog2(MP) : 1;

  logic [MP-1:0][BANK_W-1:0]  w_bank;
  logic [MP-1:0][ROW_W-1:0]   w_row;
  logic [NB-1:0][MP-1:0]      w_bank_req;
  logic [NB-1:0][MP-1:0]      w_bank_gnt;
  logic [NB-1:0]              w_bank_rvalid;
  logic [NB-1:0][PTR_W-1:0]   w_bank_rport;
  logic [NB-1:0][MemDw-1:0]   w_bank_rdata;
  logic [MP-1:0]              w_rsp_valid;
  logic [MP-1:0][MemDw-1:0]   w_rsp_data;
  logic [MP-1:0][MemDw-1:0]   rdata_q;
  logic                       unused_add;

  // Byte offset and bits above the row field do not select storage.
  assign unused_add = ^tcdm_add_i;

  generate
    for (genvar p = 0; p < MP; p++) begin : g_port_dec
      if (NB > 1) begin : g_multi_bank
        assign w_bank[p] = tcdm_add_i[p][2 +: BANK_W];
      end else begin : g_single_bank
        assign w_bank[p] = '0;
      end
      assign w_row[p] = tcdm_add_i[p][2 + NB_LOG2 +: ROW_W];
    end
  endgenerate

  always_comb begin
    w_bank_req = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned p = 0; p < MP; p++) begin
        w_bank_req[b][p] = tcdm_req_i[p] && (w_bank[p] == BANK_W'(b));
      end
    end
  end

  generate
    for (genvar b = 0; b < NB; b++) begin : g_bank
      redmule_tcdm_bank #(
        .MP    (MP),
        .DEPTH (DEPTH)
      ) i_bank (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .req_i    (w_bank_req[b]),
        .row_i    (w_row),
        .wen_i    (tcdm_wen_i),
        .be_i     (tcdm_be_i),
        .wdata_i  (tcdm_data_i),
        .gnt_o    (w_bank_gnt[b]),
        .rvalid_o (w_bank_rvalid[b]),
        .rport_o  (w_bank_rport[b]),
        .rdata_o  (w_bank_rdata[b])
      );
    end
  endgenerate

  always_comb begin
    tcdm_gnt_o = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      tcdm_gnt_o = tcdm_gnt_o | w_bank_gnt[b];
    end
  end

  // Each bank answers at most one port; OR-reduce per port across banks.
  always_comb begin
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned p = 0; p < MP; p++) begin
        if (w_bank_rvalid[b] && (w_bank_rport[b] == PTR_W'(p))) begin
          w_rsp_valid[p] = 1'b1;
          w_rsp_data[p]  = w_rsp_data[p] | w_bank_rdata[b];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      for (int unsigned p = 0; p < MP; p++) begin
        if (w_rsp_valid[p]) rdata_q[p] <= w_rsp_data[p];
      end
    end
  end

  always_comb begin
    tcdm_r_valid_o = '0;
    tcdm_r_data_o  = '0;
    if (!rst_i) begin
      tcdm_r_valid_o = w_rsp_valid;
      for (int unsigned p = 0; p < MP; p++) begin
        tcdm_r_data_o[p] = w_rsp_valid[p] ? w_rsp_data[p] : rdata_q[p];
      end
    end
  end

  assign tcdm_r_opc_o  = 1'b0;
  assign tcdm_r_user_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_redmule_tcdm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_redmule_tcdm_responder
//  Description : Directed and randomized self-checking bench against a
//                word-array reference model of the banked TCDM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_tcdm_responder;

  localparam int MP    = 4;
  localparam int NB    = 8;
  localparam int DEPTH = 256;
  localparam int WORDS = NB * DEPTH;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                stall_i;
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] wdata;
  logic [MP-1:0][31:0] rdata;
  logic [MP-1:0]       rvalid;
  logic                opc;
  logic                user;

  always #5 clk_i = ~clk_i;

  redmule_tcdm_responder #(
    .MP    (MP),
    .NB    (NB),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rvalid),
    .tcdm_r_opc_o   (opc),
    .tcdm_r_user_o  (user)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: flat word array, per-bank pointer, per-port response.
  logic [31:0] m_mem  [WORDS];
  int          m_ptr  [NB];
  bit          m_pv   [MP];
  logic [31:0] m_pd   [MP];
  logic [31:0] m_hold [MP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  function automatic logic [MP-1:0] model_gnt();
    logic [MP-1:0] g;
    int best, bestd, d;
    g = '0;
    if (rst_i || stall_i) return g;
    for (int b = 0; b < NB; b++) begin
      best  = -1;
      bestd = MP;
      for (int p = 0; p < MP; p++) begin
        if (req[p] && (word_of(add[p]) % NB == b)) begin
          d = (p - m_ptr[b] + MP) % MP;
          if (d < bestd) begin
            bestd = d;
            best  = p;
          end
        end
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  task automatic do_cycle();
    logic [MP-1:0] eg;
    logic [31:0]   ed;
    bit            ev;
    int            w;
    @(negedge clk_i);
    eg = model_gnt();
    chk("gnt", 32'(gnt), 32'(eg));
    for (int p = 0; p < MP; p++) begin
      ev = !rst_i && m_pv[p];
      ed = rst_i ? 32'h0 : (m_pv[p] ? m_pd[p] : m_hold[p]);
      chk($sformatf("r_valid[%0d]", p), 32'(rvalid[p]), 32'(ev));
      chk($sformatf("r_data[%0d]", p), rdata[p], ed);
    end
    @(posedge clk_i);
    if (rst_i) begin
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      for (int p = 0; p < MP; p++) begin
        m_pv[p]   = 1'b0;
        m_pd[p]   = '0;
        m_hold[p] = '0;
      end
    end else begin
      for (int p = 0; p < MP; p++) if (m_pv[p]) m_hold[p] = m_pd[p];
      for (int p = 0; p < MP; p++) begin
        m_pv[p] = eg[p];
        if (eg[p]) m_pd[p] = wen[p] ? m_mem[word_of(add[p])] : 32'h0;
      end
      for (int p = 0; p < MP; p++) begin
        if (eg[p]) begin
          w = word_of(add[p]);
          if (!wen[p]) begin
            for (int k = 0; k < 4; k++) if (be[p][k]) m_mem[w][8*k +: 8] = wdata[p][8*k +: 8];
          end
          m_ptr[w % NB] = (p + 1) % MP;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rst_i   = 1'b0;
    stall_i = 1'b0;
    req     = '0;
    add     = '0;
    wen     = '1;
    be      = '0;
    wdata   = '0;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    req[p]   = 1'b1;
    add[p]   = a;
    wen[p]   = w;
    be[p]    = b;
    wdata[p] = d;
  endtask

  initial begin
    logic [31:0] a;
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < MP; p++) begin
      m_pv[p]   = 1'b0;
      m_pd[p]   = '0;
      m_hold[p] = '0;
    end
    for (int i = 0; i < WORDS; i++) m_mem[i] = '0;

    // Reset with requests present
    idle();
    rst_i = 1'b1;
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 4), 1'b1, 4'hF, 32'h0);
    do_cycle();
    do_cycle();
    chk("opc", 32'(opc), 32'h0);
    chk("user", 32'(user), 32'h0);

    // Initialise words 0..63, four banks in parallel per cycle
    for (int w = 0; w < 64; w += 4) begin
      idle();
      for (int p = 0; p < MP; p++) drive(p, 32'((w + p) << 2), 1'b0, 4'hF, $urandom);
      if (w == 0) begin
        #1;
        chk("par_gnt", 32'(gnt), 32'hF);
      end
      do_cycle();
      if (w == 0) chk("par_rvalid", 32'(rvalid), 32'hF);
    end

    // Single write then read
    idle();
    drive(0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
    do_cycle();
    idle();
    drive(0, 32'h40, 1'b1, 4'h0, 32'h0);
    #1;
    chk("rd_gnt", 32'(gnt), 32'h1);
    do_cycle();
    chk("rd_data", rdata[0], 32'hDEADBEEF);

    // Byte enables
    idle();
    drive(1, 32'h80, 1'b0, 4'hF, 32'h11223344);
    do_cycle();
    idle();
    drive(1, 32'h80, 1'b0, 4'b0101, 32'hAABBCCDD);
    do_cycle();
    idle();
    drive(1, 32'h80, 1'b1, 4'h0, 32'h0);
    do_cycle();
    chk("be_data", rdata[1], 32'h11BB33DD);

    // Conflict on bank 2 straight after reset
    idle();
    rst_i = 1'b1;
    do_cycle();
    idle();
    for (int p = 0; p < MP; p++) drive(p, 32'h08, 1'b1, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("conf_gnt%0d", i), 32'(gnt), 32'(1 << i));
      do_cycle();
    end
    idle();
    do_cycle();

    // Stall: pending response still delivered, no grants or writes
    idle();
    drive(0, 32'h40, 1'b1, 4'h0, 32'h0);
    do_cycle();
    idle();
    stall_i = 1'b1;
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 4), 1'b0, 4'hF, 32'hCAFE0000 + 32'(p));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_gnt%0d", i), 32'(gnt), 32'h0);
      if (i == 0) chk("stall_rsp", rdata[0], 32'hDEADBEEF);
      do_cycle();
    end
    idle();
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 4), 1'b1, 4'h0, 32'h0);
    do_cycle();
    idle();
    do_cycle();

    // Reset in the cycle after a grant
    idle();
    drive(1, 32'h44, 1'b0, 4'hF, 32'h12345678);
    do_cycle();
    idle();
    rst_i = 1'b1;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    do_cycle();
    idle();
    do_cycle();
    idle();
    for (int p = 0; p < MP; p++) drive(p, 32'h44, 1'b1, 4'h0, 32'h0);
    #1;
    chk("rst_ptr_gnt", 32'(gnt), 32'h1);
    do_cycle();
    chk("rst_retain", rdata[0], 32'h12345678);
    idle();
    do_cycle();

    // Randomized traffic over the initialised region
    for (int c = 0; c < 400; c++) begin
      idle();
      stall_i = ($urandom_range(9) == 0);
      rst_i   = ($urandom_range(39) == 0);
      for (int p = 0; p < MP; p++) begin
        if ($urandom_range(1) == 1) begin
          a = ($urandom & ~32'h00001FFC) | (32'($urandom_range(63)) << 2);
          drive(p, a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
        end
      end
      do_cycle();
    end
    idle();
    do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
